// File: rtl/answer_generator.sv
// Secret-answer source for Bulls-and-Cows: manual load with validation, or a
// random draw of four distinct digits from a free-running Galois LFSR.
module answer_generator #(
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter bit          ALLOW_ZERO = 1'b1,
    parameter int          DRAW_LIMIT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_game,
    input  logic        load,
    input  logic [15:0] load_value,
    output logic [15:0] answer,
    output logic        answer_valid,
    output logic        busy,
    output logic        load_error
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        DRAW  = 2'd1,
        READY = 2'd2
    } state_t;

    localparam logic [7:0]  LIMIT8    = 8'(DRAW_LIMIT);
    localparam logic [15:0] LFSR_MASK = 16'hB400;

    state_t      state_reg, state_next;
    logic [15:0] lfsr_reg, lfsr_next;
    logic [1:0]  idx_reg, idx_next;
    logic [7:0]  draw_cnt_reg, draw_cnt_next;
    logic [15:0] answer_reg, answer_next;
    logic        valid_reg, valid_next;
    logic        busy_reg, busy_next;
    logic        load_error_reg, load_error_next;

    logic [3:0]  load_nib [4];
    logic [3:0]  slot_digit [4];
    logic [3:0]  slot_filled;
    logic [15:0] used_mask;
    logic        load_ok;
    logic [3:0]  fill_digit;
    logic [3:0]  candidate;
    logic        cand_ok;

    function automatic logic is_legal(input logic [3:0] d);
        return (d <= 4'd9) && (ALLOW_ZERO || (d != 4'd0));
    endfunction

    // Nibble views of the load word and of the answer slots (slot 0 = MSB nibble).
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign load_nib[gi]    = load_value[15 - 4*gi -: 4];
            assign slot_digit[gi]  = answer_reg[15 - 4*gi -: 4];
            assign slot_filled[gi] = (2'(gi) < idx_reg);
        end
    endgenerate

    always_comb begin
        load_ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (!is_legal(load_nib[i])) begin
                load_ok = 1'b0;
            end
            for (int j = i + 1; j < 4; j++) begin
                if (load_nib[i] == load_nib[j]) begin
                    load_ok = 1'b0;
                end
            end
        end
    end

    // Digits already committed during the current draw.
    always_comb begin
        used_mask = '0;
        for (int i = 0; i < 4; i++) begin
            if (slot_filled[i]) begin
                used_mask[slot_digit[i]] = 1'b1;
            end
        end
    end

    // Descending scan so the last hit is the lowest free legal digit.
    always_comb begin
        fill_digit = 4'd0;
        for (int d = 9; d >= 0; d--) begin
            if (is_legal(4'(d)) && !used_mask[4'(d)]) begin
                fill_digit = 4'(d);
            end
        end
    end

    always_comb begin
        candidate = (draw_cnt_reg < LIMIT8) ? lfsr_reg[3:0] : fill_digit;
        cand_ok   = is_legal(candidate) && !used_mask[candidate];
    end

    always_comb begin
        if (lfsr_reg == 16'h0000) begin
            lfsr_next = 16'h0001;
        end else begin
            lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? LFSR_MASK : 16'h0000);
        end
    end

    always_comb begin
        state_next      = state_reg;
        idx_next        = idx_reg;
        draw_cnt_next   = draw_cnt_reg;
        answer_next     = answer_reg;
        valid_next      = valid_reg;
        busy_next       = busy_reg;
        load_error_next = 1'b0;

        case (state_reg)
            EMPTY, READY: begin
                if (load) begin
                    if (load_ok) begin
                        answer_next = load_value;
                        valid_next  = 1'b1;
                        state_next  = READY;
                    end else begin
                        load_error_next = 1'b1;
                    end
                end else if (new_game) begin
                    state_next    = DRAW;
                    busy_next     = 1'b1;
                    valid_next    = 1'b0;
                    answer_next   = 16'h0000;
                    idx_next      = 2'd0;
                    draw_cnt_next = 8'd0;
                end
            end
            DRAW: begin
                load_error_next = load;
                if (draw_cnt_reg != 8'hFF) begin
                    draw_cnt_next = draw_cnt_reg + 8'd1;
                end
                if (cand_ok) begin
                    for (int i = 0; i < 4; i++) begin
                        if (idx_reg == 2'(i)) begin
                            answer_next[15 - 4*i -: 4] = candidate;
                        end
                    end
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        state_next = READY;
                        busy_next  = 1'b0;
                        valid_next = 1'b1;
                    end
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= EMPTY;
            lfsr_reg       <= SEED;
            idx_reg        <= 2'd0;
            draw_cnt_reg   <= 8'd0;
            answer_reg     <= 16'h0000;
            valid_reg      <= 1'b0;
            busy_reg       <= 1'b0;
            load_error_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            lfsr_reg       <= lfsr_next;
            idx_reg        <= idx_next;
            draw_cnt_reg   <= draw_cnt_next;
            answer_reg     <= answer_next;
            valid_reg      <= valid_next;
            busy_reg       <= busy_next;
            load_error_reg <= load_error_next;
        end
    end

    assign answer       = answer_reg;
    assign answer_valid = valid_reg;
    assign busy         = busy_reg;
    assign load_error   = load_error_reg;

endmodule

// File: tb/tb_answer_generator.sv
// Bench for answer_generator: directed loads/fill draws plus a long random run
// against a queue-based reference model of the draw rules.
module tb_answer_generator;

    localparam logic [15:0] SEED  = 16'hACE1;
    localparam int          LIMIT = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, new_game, load;
    logic [15:0] load_value;
    logic [15:0] answer;
    logic        answer_valid, busy, load_error;

    logic        new_game_f, load_f;
    logic [15:0] load_value_f;
    logic [15:0] answer_f1, answer_f0;
    logic        valid_f1, busy_f1, lerr_f1;
    logic        valid_f0, busy_f0, lerr_f0;

    answer_generator #(.SEED(SEED), .ALLOW_ZERO(1'b1), .DRAW_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst), .new_game(new_game), .load(load), .load_value(load_value),
        .answer(answer), .answer_valid(answer_valid), .busy(busy), .load_error(load_error)
    );

    answer_generator #(.SEED(SEED), .ALLOW_ZERO(1'b1), .DRAW_LIMIT(0)) dut_f1 (
        .clk(clk), .rst(rst), .new_game(new_game_f), .load(load_f), .load_value(load_value_f),
        .answer(answer_f1), .answer_valid(valid_f1), .busy(busy_f1), .load_error(lerr_f1)
    );

    answer_generator #(.SEED(SEED), .ALLOW_ZERO(1'b0), .DRAW_LIMIT(0)) dut_f0 (
        .clk(clk), .rst(rst), .new_game(new_game_f), .load(load_f), .load_value(load_value_f),
        .answer(answer_f0), .answer_valid(valid_f0), .busy(busy_f0), .load_error(lerr_f0)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: digits drawn so far kept as a queue.
    bit          m_drawing;
    int          m_lfsr;
    int          m_digits[$];
    int          m_cnt;
    logic [15:0] m_answer;
    bit          m_valid;
    bit          m_lerr;
    int          ng_accepted = 0;

    function automatic bit legal(input int d, input bit az);
        return (d <= 9) && (az || d != 0);
    endfunction

    function automatic bit has(input int q[$], input int d);
        foreach (q[i]) if (q[i] == d) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit load_good(input logic [15:0] v, input bit az);
        int seen[$];
        for (int i = 0; i < 4; i++) begin
            int d;
            d = int'((v >> (12 - 4*i)) & 16'hF);
            if (!legal(d, az) || has(seen, d)) return 1'b0;
            seen.push_back(d);
        end
        return 1'b1;
    endfunction

    function automatic logic [15:0] pack(input int q[$]);
        logic [15:0] r;
        r = 16'h0000;
        foreach (q[i]) r = r | (16'(q[i]) << (12 - 4*i));
        return r;
    endfunction

    task automatic model_step(input bit r, input bit ng, input bit ld, input logic [15:0] lv);
        int old_lfsr, old_cnt, cand;
        if (r) begin
            m_drawing = 0; m_lfsr = int'(SEED); m_digits = {}; m_cnt = 0;
            m_answer = 16'h0000; m_valid = 0; m_lerr = 0;
            return;
        end
        old_lfsr = m_lfsr;
        m_lfsr = (old_lfsr == 0) ? 1 : ((old_lfsr >> 1) ^ ((old_lfsr & 1) != 0 ? 'hB400 : 0));
        m_lerr = 0;
        if (m_drawing) begin
            m_lerr = ld;
            old_cnt = m_cnt;
            if (m_cnt < 255) m_cnt++;
            if (old_cnt < LIMIT) begin
                cand = old_lfsr & 15;
            end else begin
                cand = -1;
                for (int d = 0; d <= 9 && cand < 0; d++)
                    if (legal(d, 1'b1) && !has(m_digits, d)) cand = d;
            end
            if (legal(cand, 1'b1) && !has(m_digits, cand)) begin
                m_digits.push_back(cand);
                m_answer = pack(m_digits);
                if (m_digits.size() == 4) begin
                    m_drawing = 0;
                    m_valid = 1;
                end
            end
        end else if (ld) begin
            if (load_good(lv, 1'b1)) begin
                m_answer = lv;
                m_valid = 1;
            end else begin
                m_lerr = 1;
            end
        end else if (ng) begin
            m_drawing = 1; m_valid = 0; m_answer = 16'h0000; m_digits = {}; m_cnt = 0;
            ng_accepted++;
        end
    endtask

    int run_len = 0;
    bit prev_busy = 0;

    task automatic cycle(input bit r, input bit ng, input bit ld, input logic [15:0] lv);
        rst = r; new_game = ng; load = ld; load_value = lv;
        @(posedge clk);
        model_step(r, ng, ld, lv);
        #1;
        check("answer", answer, m_answer);
        check("answer_valid", answer_valid, m_valid);
        check("busy", busy, m_drawing);
        check("load_error", load_error, m_lerr);
        if (busy) begin
            run_len++;
        end else begin
            if (prev_busy && answer_valid) begin
                check("draw_latency_ok", run_len <= LIMIT + 4, 1);
                check("digits_ok", load_good(answer, 1'b1), 1);
            end
            run_len = 0;
        end
        prev_busy = busy;
    endtask

    function automatic logic [15:0] rand_valid_word();
        int q[$];
        while (q.size() < 4) begin
            int d;
            d = int'($urandom_range(0, 9));
            if (!has(q, d)) q.push_back(d);
        end
        return pack(q);
    endfunction

    initial begin
        logic [15:0] bad [2];
        bad[0] = 16'h1123;
        bad[1] = 16'h12A4;
        new_game_f = 0; load_f = 0; load_value_f = 16'h0000;
        model_step(1, 0, 0, 16'h0000);

        cycle(1, 0, 0, 16'h0000);
        cycle(1, 0, 0, 16'h0000);
        check("rst_answer", answer, 16'h0000);
        check("rst_valid", answer_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_load_error", load_error, 0);
        check("rst_f1_busy", busy_f1, 0);
        check("rst_f0_valid", valid_f0, 0);
        repeat (3) cycle(0, 0, 0, 16'h0000);
        check("idle_answer", answer, 16'h0000);
        check("idle_valid", answer_valid, 0);

        cycle(0, 0, 1, 16'h1234);
        check("load_1234", answer, 16'h1234);
        check("load_valid", answer_valid, 1);
        check("load_no_err", load_error, 0);
        foreach (bad[i]) begin
            cycle(0, 0, 1, bad[i]);
            check("bad_load_err", load_error, 1);
            check("bad_load_kept", answer, 16'h1234);
            cycle(0, 0, 0, 16'h0000);
            check("bad_load_pulse_end", load_error, 0);
        end

        load_f = 1; load_value_f = 16'h1234;
        cycle(0, 0, 0, 16'h0000);
        load_f = 0;
        check("f0_load_1234", answer_f0, 16'h1234);
        load_f = 1; load_value_f = 16'h0123;
        cycle(0, 0, 0, 16'h0000);
        load_f = 0;
        check("f0_zero_reject", lerr_f0, 1);
        check("f0_zero_kept", answer_f0, 16'h1234);
        check("f1_zero_accept", answer_f1, 16'h0123);
        check("f1_zero_no_err", lerr_f1, 0);
        cycle(0, 0, 0, 16'h0000);
        check("f0_err_pulse_end", lerr_f0, 0);

        new_game_f = 1;
        cycle(0, 0, 0, 16'h0000);
        new_game_f = 0;
        check("f0_valid_cleared", valid_f0, 0);
        for (int k = 0; k < 4; k++) begin
            check("f1_fill_busy", busy_f1, 1);
            check("f0_fill_busy", busy_f0, 1);
            cycle(0, 0, 0, 16'h0000);
        end
        check("f1_fill_done", busy_f1, 0);
        check("f0_fill_done", busy_f0, 0);
        check("f1_fill_answer", answer_f1, 16'h0123);
        check("f0_fill_answer", answer_f0, 16'h1234);
        check("f1_fill_valid", valid_f1, 1);
        check("f0_fill_valid", valid_f0, 1);

        cycle(0, 1, 0, 16'h0000);
        for (int t = 0; t < 100 && m_digits.size() < 2; t++) cycle(0, 0, 0, 16'h0000);
        check("mid_draw_busy", busy, 1);
        cycle(1, 0, 0, 16'h0000);
        check("mid_rst_answer", answer, 16'h0000);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_valid", answer_valid, 0);
        cycle(0, 1, 0, 16'h0000);
        for (int t = 0; t < LIMIT + 10 && busy; t++) cycle(0, 0, 0, 16'h0000);
        check("post_rst_draw_valid", answer_valid, 1);
        check("post_rst_draw_digits", load_good(answer, 1'b1), 1);

        ng_accepted = 0;
        for (int c = 0; c < 60000 && ng_accepted < 1000; c++) begin
            bit ng, ld;
            logic [15:0] lv;
            ng = ($urandom_range(0, 9) == 0);
            ld = ($urandom_range(0, 15) == 0);
            lv = ($urandom_range(0, 1) == 1) ? rand_valid_word() : 16'($urandom);
            cycle(0, ng, ld, lv);
        end
        check("new_game_count", ng_accepted, 1000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/answer_generator.md
# answer_generator

Produces the secret 4-digit BCD answer consumed by the Bulls-and-Cows comparator, the setter end of the guess/answer pair. A second player can load an answer manually, or a new_game pulse draws four distinct random digits from a free-running LFSR. The answer is validated, either on load or during the draw, before answer_valid rises. The block replaces the fixed answer constant at top level.

## Interface
- SEED, 16'hACE1, LFSR reset value; must be nonzero
- ALLOW_ZERO, 1, 1: digit 0 legal in any slot; 0: digits restricted to 1..9
- DRAW_LIMIT, 64, DRAW cycles (0..255) before deterministic fill takes over
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- new_game  in  1  level sampled each clk; starts a random draw
- load  in  1  level sampled each clk; manual answer write
- load_value  in  16  manual answer, digit1 in [15:12] … digit4 in [3:0]
- answer  out  16  current answer, same packing
- answer_valid  out  1  answer holds 4 legal, distinct digits
- busy  out  1  draw in progress
- load_error  out  1  one-cycle pulse: load rejected

## Operation
- States: EMPTY, DRAW, READY. Reset: state EMPTY, answer 16'h0000, answer_valid 0, busy 0, load_error 0, lfsr SEED, idx 0, draw_cnt 0.
- LFSR: 16-bit Galois, mask 16'hB400, advances every cycle in every state. If it ever reads 0, it loads 16'h0001 instead.
- Legal digit: value ≤ 9, and ≥ 1 when ALLOW_ZERO=0.
- EMPTY/READY + load: accept if all four nibbles are legal and pairwise distinct.
  - Accept: answer ← load_value, answer_valid ← 1, state READY.
  - Reject: load_error pulses, state and answer unchanged.
- EMPTY/READY + new_game (no load): state DRAW, busy ← 1, answer_valid ← 0, answer ← 0, idx ← 0, draw_cnt ← 0.
- load and new_game in the same cycle: load wins; new_game is dropped.
- DRAW, one candidate per cycle:
  - When draw_cnt < DRAW_LIMIT, the candidate is lfsr[3:0].
  - Otherwise (fill mode), the candidate is the lowest legal digit not yet in slots 0..idx-1.
  - The candidate is accepted if it is legal and differs from all filled slots. On accept it is written to slot idx (slot 0 is [15:12]) and idx increments.
  - draw_cnt increments each DRAW cycle and saturates at 255.
- DRAW exit: on the accept that fills slot 3, state READY, busy ← 0, answer_valid ← 1.
- In DRAW, new_game is ignored. load is ignored and load_error pulses.
- In READY, answer is held until the next accepted load or new_game.
- rst in any state, including mid-DRAW, returns all reset values on the next edge. No partial answer survives.

## Timing
- All outputs are registered; no combinational input-to-output path.
- load accepted at edge N: answer and answer_valid update at edge N+1. A rejected load gives load_error high for exactly the cycle after N.
- new_game at edge N: busy=1 and answer_valid=0 from N+1. DRAW spans at least 4 cycles, so the earliest answer_valid=1 is N+5.
- Worst case: answer_valid by N+1+DRAW_LIMIT+4, since fill mode accepts every cycle.
- Holding new_game or load high re-triggers on every cycle it is accepted. A held new_game in READY restarts the draw on the next cycle.

## Test plan
- Reset: assert rst 2 cycles → answer 16'h0000, answer_valid 0, busy 0, load_error 0. Outputs stay there until a load or new_game.
- Valid manual load: load=1, load_value=16'h1234 in EMPTY → next cycle answer 16'h1234, answer_valid 1, load_error 0.
- Illegal loads:
  - 16'h1123 rejected (duplicate) → load_error 1 for one cycle.
  - 16'h12A4 rejected (nibble > 9) → load_error 1 for one cycle.
  - ALLOW_ZERO=0: 16'h0123 rejected → load_error 1 for one cycle.
  - In every case the prior answer 16'h1234 is kept.
- Deterministic fill, DRAW_LIMIT=0:
  - ALLOW_ZERO=1: new_game → busy for exactly 4 cycles, then answer 16'h0123, answer_valid 1.
  - ALLOW_ZERO=0: same sequence, answer 16'h1234.
- Random draw, defaults: 1000 new_game pulses at random spacing → every answer has 4 legal, distinct digits, and answer_valid rises within DRAW_LIMIT+5 cycles. In parallel, a load during busy gives a load_error pulse with no state change, and load+new_game together gives load priority.
- Reset mid-DRAW: pulse rst after 2 accepted digits → answer 0, busy 0, answer_valid 0 next cycle. A following new_game completes normally.
